// File: rtl/mul_stage_vec_if.sv
// rtl/mul_stage_vec_if.sv - handshake and data bundle for the multi-lane FP multiply stage
// Signals:
//   srcReady              upstream offers in_A/in_B/mode
//   readyForInput         stage can accept this cycle
//   in_A, in_B            operand vectors, DATA_W bits
//   mode                  0 = plain multiply, 1 = multiply then ReLU
//   outputReadyEn         multiplicationResult valid
//   destReady             downstream accepts result this cycle
//   multiplicationResult  product vector, DATA_W bits
// Modports: master = producer/consumer side, slave = the multiply stage.
interface mul_stage_vec_if #(
    parameter int DATA_W = 32
);
    logic              srcReady;
    logic              readyForInput;
    logic [DATA_W-1:0] in_A;
    logic [DATA_W-1:0] in_B;
    logic              mode;
    logic              outputReadyEn;
    logic              destReady;
    logic [DATA_W-1:0] multiplicationResult;

    modport master (
        output srcReady, in_A, in_B, mode, destReady,
        input  readyForInput, outputReadyEn, multiplicationResult
    );

    modport slave (
        input  srcReady, in_A, in_B, mode, destReady,
        output readyForInput, outputReadyEn, multiplicationResult
    );
endinterface

// File: rtl/mul_stage_vec.sv
// rtl/mul_stage_vec.sv - three-stage pipelined multi-lane floating-point multiplier with ReLU
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  mul_stage_vec_if.slave: srcReady/readyForInput input handshake, in_A/in_B/mode,
//        outputReadyEn/destReady output handshake, multiplicationResult
// Stages: S1 unpack/classify/exp add/mantissa product, S2 normalise + round-nearest-even,
//         S3 pack/specials/ReLU registered onto the outputs.
module mul_stage_vec #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int LANES = 2
) (
    input logic           clk,
    input logic           rst,
    mul_stage_vec_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MP = 2 * (MAN_W + 1);
    // Exponent carried with two spare bits so underflow (negative) and overflow stay visible.
    localparam int EW = EXP_W + 2;
    localparam logic [EW-1:0]        BIAS    = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    localparam logic [1:0] CLS_NORM = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    logic stall;
    assign stall             = bus.outputReadyEn & ~bus.destReady;
    assign bus.readyForInput = ~stall;

    logic                        s1Valid, s2Valid, s1Mode, s2Mode;
    logic [LANES-1:0]            s1Sign, s2Sign;
    logic [LANES-1:0][1:0]       s1Cls, s2Cls;
    logic [LANES-1:0][EW-1:0]    s1Exp, s2Exp;
    logic [LANES-1:0][MP-1:0]    s1Prod;
    logic [LANES-1:0][MAN_W-1:0] s2Man;

    logic [LANES-1:0]            c1Sign;
    logic [LANES-1:0][1:0]       c1Cls;
    logic [LANES-1:0][EW-1:0]    c1Exp, c2Exp;
    logic [LANES-1:0][MP-1:0]    c1Prod;
    logic [LANES-1:0][MAN_W-1:0] c2Man;
    logic [LANES*W-1:0]          c3Res;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic             sA, sB;
        logic [EXP_W-1:0] eA, eB;
        logic [MAN_W-1:0] mA, mB;
        logic             zA, zB, infA, infB, nanA, nanB;

        assign {sA, eA, mA} = bus.in_A[i*W +: W];
        assign {sB, eB, mB} = bus.in_B[i*W +: W];

        // Denormals count as zero: they are flushed rather than multiplied.
        assign zA   = (eA == '0);
        assign zB   = (eB == '0);
        assign infA = (eA == '1) && (mA == '0);
        assign infB = (eB == '1) && (mB == '0);
        assign nanA = (eA == '1) && (mA != '0);
        assign nanB = (eB == '1) && (mB != '0);

        always_comb begin
            c1Sign[i] = sA ^ sB;
            c1Exp[i]  = EW'(eA) + EW'(eB) - BIAS;
            c1Prod[i] = MP'({1'b1, mA}) * MP'({1'b1, mB});
            if (nanA || nanB || (infA && zB) || (infB && zA)) begin
                c1Cls[i] = CLS_NAN;
            end else if (infA || infB) begin
                c1Cls[i] = CLS_INF;
            end else if (zA || zB) begin
                c1Cls[i] = CLS_ZERO;
            end else begin
                c1Cls[i] = CLS_NORM;
            end
        end

        // Product lies in [1,4); one left shift aligns the hidden bit to the MSB.
        logic [MP-1:0]    normP;
        logic [MAN_W:0]   kept;
        logic             guardBit, stickyBit;
        logic [MAN_W+1:0] rounded;

        always_comb begin
            normP     = s1Prod[i][MP-1] ? s1Prod[i] : (s1Prod[i] << 1);
            kept      = normP[MP-1 -: MAN_W+1];
            guardBit  = normP[MAN_W];
            stickyBit = |normP[MAN_W-1:0];
            rounded   = {1'b0, kept} + (MAN_W+2)'(guardBit & (stickyBit | kept[0]));
            // Rounding carry out leaves 1.000..0 x 2, so the stored field is all zeros.
            c2Exp[i]  = s1Exp[i] + EW'(s1Prod[i][MP-1]) + EW'(rounded[MAN_W+1]);
            c2Man[i]  = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
        end

        logic [W-1:0]          laneRes;
        logic signed [EW-1:0]  expS;

        always_comb begin
            laneRes = '0;
            expS    = $signed(s2Exp[i]);
            case (s2Cls[i])
                CLS_NAN:  laneRes = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                CLS_INF:  laneRes = {s2Sign[i], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                CLS_ZERO: laneRes = {s2Sign[i], {(W-1){1'b0}}};
                default: begin
                    if (expS >= EXP_MAX) begin
                        laneRes = {s2Sign[i], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else if (expS <= 0) begin
                        laneRes = {s2Sign[i], {(W-1){1'b0}}};
                    end else begin
                        laneRes = {s2Sign[i], s2Exp[i][EXP_W-1:0], s2Man[i]};
                    end
                end
            endcase
            // Canonical NaN is positive, so only genuinely negative results are clamped.
            if (s2Mode && laneRes[W-1]) begin
                laneRes = '0;
            end
        end

        assign c3Res[i*W +: W] = laneRes;
    end

    // Every stage advances together; a stall freezes the whole pipe including bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1Valid                  <= 1'b0;
            s2Valid                  <= 1'b0;
            s1Mode                   <= 1'b0;
            s2Mode                   <= 1'b0;
            s1Sign                   <= '0;
            s2Sign                   <= '0;
            s1Cls                    <= '0;
            s2Cls                    <= '0;
            s1Exp                    <= '0;
            s2Exp                    <= '0;
            s1Prod                   <= '0;
            s2Man                    <= '0;
            bus.outputReadyEn        <= 1'b0;
            bus.multiplicationResult <= '0;
        end else if (!stall) begin
            s1Valid                  <= bus.srcReady;
            s1Mode                   <= bus.mode;
            s1Sign                   <= c1Sign;
            s1Cls                    <= c1Cls;
            s1Exp                    <= c1Exp;
            s1Prod                   <= c1Prod;
            s2Valid                  <= s1Valid;
            s2Mode                   <= s1Mode;
            s2Sign                   <= s1Sign;
            s2Cls                    <= s1Cls;
            s2Exp                    <= c2Exp;
            s2Man                    <= c2Man;
            bus.outputReadyEn        <= s2Valid;
            bus.multiplicationResult <= c3Res;
        end
    end
endmodule
